vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised successor to the fixed 640x480 VGA timing controller: generates hSync/vSync, row/column
//  and displayActive for any resolution/polarity from a single clock with a pixel clock-enable.
//  Adds a line-prefetch handshake (lineReq/lineAck) so a memory client (DDR line buffer) fetches
//  each active row one line ahead, plus a sticky underrun flag and a frameStart pulse.
// PARAMETERS
//  H_ACTIVE 640  visible pixels per line        H_FP 16   H_SYNC 96   H_BP 48   (pixels)
//  V_ACTIVE 480  visible lines per frame        V_FP 10   V_SYNC 2    V_BP 33   (lines)
//  H_POL    0    hSync active level (0=low)     V_POL 0   vSync active level (0=low)
//  COL_W    10   width of column/h counter      ROW_W 10  width of row/v counter/lineRow
// PORTS
//  clk           in   1      single design clock
//  rst           in   1      synchronous reset, ACTIVE-LOW
//  pixEn         in   1      pixel clock-enable; counters advance only on clk edges with pixEn=1
//  enable        in   1      0 = timing held at origin, outputs blanked
//  lineAck       in   1      client accepted the current lineReq
//  clearUnderrun in   1      clears the underrun flag
//  hSync, vSync  out  1      sync outputs, polarity per H_POL/V_POL
//  column        out  COL_W  horizontal position in active area (0 when blanked)
//  row           out  ROW_W  vertical position in active area (0 when blanked)
//  displayActive out  1      1 when h<H_ACTIVE and v<V_ACTIVE
//  frameStart    out  1      one-clk pulse when (h,v) becomes (0,0)
//  lineReq       out  1      request to fetch row lineRow; held until lineAck
//  lineRow       out  ROW_W  row to be fetched, stable while lineReq=1
//  underrun      out  1      sticky: a requested row was not acked before display began
// BEHAVIOUR
//  - HT=H_ACTIVE+H_FP+H_SYNC+H_BP, VT=V_ACTIVE+V_FP+V_SYNC+V_BP. Internal counters h in [0,HT-1],
//    v in [0,VT-1]; on pixEn: h wraps HT-1->0 and v increments; v wraps VT-1->0.
//  - All outputs registered: they reflect the (h,v) held by the counters in the previous clk (1-clk latency).
//  - hSync active for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vSync likewise on v; both over full lines.
//  - column=h, row=v when displayActive, else 0. frameStart pulses 1 clk only (not per pixEn held).
//  - Reset (rst=0 at clk edge): h=v=0, hSync=~H_POL, vSync=~V_POL, displayActive=0, column=row=0,
//    frameStart=0, lineReq=0, lineRow=0, underrun=0. Mid-frame reset aborts any pending request silently.
//  - enable=0: h,v forced to 0, syncs inactive, displayActive=0, lineReq dropped, no underrun; on
//    enable 0->1 timing starts at (0,0) and frameStart pulses.
//  - Prefetch FSM states IDLE, REQ.
//    IDLE->REQ when counters step to h==H_ACTIVE and next line n=(v+1)%VT < V_ACTIVE:
//    lineRow<=n, lineReq<=1. Line V_ACTIVE-1 issues no request; line VT-1 requests row 0.
//    REQ->IDLE on lineAck=1: lineReq falls the next clk. lineAck in IDLE is ignored.
//    REQ->IDLE by abandon when counters step to h==0 on v==lineRow: lineReq falls, underrun<=1.
//    Ack and abandon in the same clk: ack wins, underrun unchanged.
//  - underrun set by abandon, cleared by clearUnderrun; set and clear in same clk: set wins.
//  - Parameters with H_ACTIVE<2 or any zero porch/sync width are unsupported.
// TESTING
//  1 rst=0 5 clks, defaults -> hSync=vSync=1, displayActive=0, lineReq=0, underrun=0, row=column=0.
//  2 defaults, pixEn every 2nd clk -> hSync low exactly 96 pixEn at h=656..751, line=800 pixEn,
//    vSync low on v=490..491, frameStart every 420000 pixEn, displayActive 640x480 per frame.
//  3 lineAck 3 clks after lineReq rise -> lineReq high 4 clks, lineRow=1 at end of line 0,
//    no request on line 479, lineRow=0 on line 524; underrun stays 0 over 2 frames.
//  4 lineAck tied 0 -> underrun rises at first pixel of row 1, lineReq falls same clk;
//    clearUnderrun pulse -> underrun=0 until next abandon.
//  5 lineAck asserted on exactly the abandon clk -> lineReq falls, underrun stays 0.
//  6 H_ACTIVE=4,H_FP=H_SYNC=H_BP=1,V_ACTIVE=3,V_FP=V_SYNC=V_BP=1,H_POL=V_POL=1 -> HT=7, VT=6,
//    hSync high only at h=5; mid-frame rst=0 returns all outputs to reset values next clk.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with pixel clock-enable; every output is registered one clk behind the h/v counters.
// Backpressure: lineReq holds until lineAck; a row still unacked at its first pixel is dropped and flags underrun.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0,
  parameter int   COL_W    = 10,
  parameter int   ROW_W    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pixEn,
  input  logic             enable,
  input  logic             lineAck,
  input  logic             clearUnderrun,
  output logic             hSync,
  output logic             vSync,
  output logic [COL_W-1:0] column,
  output logic [ROW_W-1:0] row,
  output logic             displayActive,
  output logic             frameStart,
  output logic             lineReq,
  output logic [ROW_W-1:0] lineRow,
  output logic             underrun
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COL_W-1:0] H_LAST   = COL_W'(HT - 1);
  localparam logic [COL_W-1:0] H_ACT    = COL_W'(H_ACTIVE);
  localparam logic [COL_W-1:0] H_REQ_AT = COL_W'(H_ACTIVE - 1);
  localparam logic [COL_W-1:0] HS_BEG   = COL_W'(H_ACTIVE + H_FP);
  localparam logic [COL_W-1:0] HS_END   = COL_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [ROW_W-1:0] V_LAST   = ROW_W'(VT - 1);
  localparam logic [ROW_W-1:0] V_ACT    = ROW_W'(V_ACTIVE);
  localparam logic [ROW_W-1:0] VS_BEG   = ROW_W'(V_ACTIVE + V_FP);
  localparam logic [ROW_W-1:0] VS_END   = ROW_W'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {IDLE, REQ} pf_state_t;

  pf_state_t        state, state_nxt;
  logic [COL_W-1:0] h;
  logic [ROW_W-1:0] v, v_nxt, row_nxt;
  logic             h_wrap, v_wrap, step, req_fire, abandon, und_nxt;
  logic             active, hs_on, vs_on;
  logic             origin_new;

  always_comb begin
    h_wrap   = (h == H_LAST);
    v_wrap   = (v == V_LAST);
    v_nxt    = v_wrap ? '0 : v + 1'b1;
    step     = enable & pixEn;
    active   = (h < H_ACT) && (v < V_ACT);
    hs_on    = (h >= HS_BEG) && (h < HS_END);
    vs_on    = (v >= VS_BEG) && (v < VS_END);
    // Request the next line as the counters leave the active part of this one.
    req_fire = step && (h == H_REQ_AT) && (v_nxt < V_ACT);
  end

  always_comb begin
    state_nxt = state;
    row_nxt   = lineRow;
    abandon   = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (req_fire) begin
            state_nxt = REQ;
            row_nxt   = v_nxt;
          end
        end
        REQ: begin
          // An ack arriving on the abandon edge still counts as in time.
          if (lineAck) begin
            state_nxt = IDLE;
          end else if (step && h_wrap && (v_nxt == lineRow)) begin
            state_nxt = IDLE;
            abandon   = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    und_nxt = abandon ? 1'b1 : (clearUnderrun ? 1'b0 : underrun);
  end

  assign lineReq = (state == REQ);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      lineRow       <= '0;
      underrun      <= 1'b0;
      h             <= '0;
      v             <= '0;
      origin_new    <= 1'b1;
      hSync         <= ~H_POL;
      vSync         <= ~V_POL;
      displayActive <= 1'b0;
      column        <= '0;
      row           <= '0;
      frameStart    <= 1'b0;
    end else begin
      state    <= state_nxt;
      lineRow  <= row_nxt;
      underrun <= und_nxt;
      if (!enable) begin
        h             <= '0;
        v             <= '0;
        origin_new    <= 1'b1;
        hSync         <= ~H_POL;
        vSync         <= ~V_POL;
        displayActive <= 1'b0;
        column        <= '0;
        row           <= '0;
        frameStart    <= 1'b0;
      end else begin
        if (pixEn) begin
          h <= h_wrap ? '0 : h + 1'b1;
          if (h_wrap) v <= v_nxt;
        end
        // origin_new marks the first clk spent at (0,0), so frameStart fires once per frame.
        origin_new    <= pixEn && h_wrap && v_wrap;
        hSync         <= hs_on ? H_POL : ~H_POL;
        vSync         <= vs_on ? V_POL : ~V_POL;
        displayActive <= active;
        column        <= active ? h : '0;
        row           <= active ? v : '0;
        frameStart    <= origin_new;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: a tiny-geometry instance checked against a position-based model through a scoreboard queue,
// plus directed line-level sequences on a default 640x480 instance.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Small instance: HT=7, VT=6, active-high syncs.
  logic       s_rst, s_pix, s_en, s_ack, s_clr;
  logic       s_hs, s_vs, s_da, s_fs, s_lq, s_ur;
  logic [2:0] s_col, s_row, s_lr;

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .COL_W(3), .ROW_W(3)
  ) dut_s (
    .clk(clk), .rst(s_rst), .pixEn(s_pix), .enable(s_en), .lineAck(s_ack),
    .clearUnderrun(s_clr), .hSync(s_hs), .vSync(s_vs), .column(s_col), .row(s_row),
    .displayActive(s_da), .frameStart(s_fs), .lineReq(s_lq), .lineRow(s_lr), .underrun(s_ur)
  );

  // Default 640x480 instance.
  logic       d_rst, d_pix, d_en, d_ack, d_clr;
  logic       d_hs, d_vs, d_da, d_fs, d_lq, d_ur;
  logic [9:0] d_col, d_row, d_lr;

  vga_timing_gen dut_d (
    .clk(clk), .rst(d_rst), .pixEn(d_pix), .enable(d_en), .lineAck(d_ack),
    .clearUnderrun(d_clr), .hSync(d_hs), .vSync(d_vs), .column(d_col), .row(d_row),
    .displayActive(d_da), .frameStart(d_fs), .lineReq(d_lq), .lineRow(d_lr), .underrun(d_ur)
  );

  typedef struct packed {
    logic       hs, vs, da, fs, lq, ur;
    logic [2:0] col, row, lr;
  } sobs_t;

  typedef struct {
    logic  r, p, e, a, c;
    sobs_t exp;
  } vec_t;

  sobs_t exp_q[$];
  vec_t  vt[15];

  // Model state for the small instance: linear pixel position within the frame.
  int m_pos, m_lrow;
  bit m_org, m_st, m_und;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic sobs_t mko(input logic hs, vs, da, fs, lq, ur, input int col, row, lr);
    sobs_t o;
    o.hs = hs; o.vs = vs; o.da = da; o.fs = fs; o.lq = lq; o.ur = ur;
    o.col = 3'(col); o.row = 3'(row); o.lr = 3'(lr);
    return o;
  endfunction

  function automatic vec_t mkv(input logic r, p, e, a, c, input sobs_t ex);
    vec_t x;
    x.r = r; x.p = p; x.e = e; x.a = a; x.c = c; x.exp = ex;
    return x;
  endfunction

  task automatic model(input logic r, p, e, a, c, output sobs_t o);
    int  hh, vv, np;
    bit  ab, act;
    hh = m_pos % 7;
    vv = m_pos / 7;
    ab = 1'b0;
    np = 0;
    if (!r) begin
      m_pos = 0; m_org = 1'b1; m_st = 1'b0; m_und = 1'b0; m_lrow = 0;
      o = mko(0, 0, 0, 0, 0, 0, 0, 0, 0);
      return;
    end
    if (!e) begin
      o = mko(0, 0, 0, 0, 0, 0, 0, 0, 0);
      m_st = 1'b0;
    end else begin
      act = (hh < 4) && (vv < 3);
      o = mko(hh == 5, vv == 4, act, m_org, 0, 0, act ? hh : 0, act ? vv : 0, 0);
      np = p ? (m_pos + 1) % 42 : m_pos;
      if (m_st) begin
        if (a) m_st = 1'b0;
        else if (p && (np % 7 == 0) && (np / 7 == m_lrow)) begin
          m_st = 1'b0;
          ab = 1'b1;
        end
      end else if (p && (np % 7 == 4) && ((vv + 1) % 6 < 3)) begin
        m_st = 1'b1;
        m_lrow = (vv + 1) % 6;
      end
    end
    if (ab) m_und = 1'b1;
    else if (c) m_und = 1'b0;
    m_org = !e || (p && m_pos == 41);
    m_pos = np;
    o.lq = m_st;
    o.ur = m_und;
    o.lr = 3'(m_lrow);
  endtask

  task automatic s_apply(input string name, input logic r, p, e, a, c, input sobs_t ex);
    sobs_t got, want;
    s_rst = r; s_pix = p; s_en = e; s_ack = a; s_clr = c;
    exp_q.push_back(ex);
    @(posedge clk);
    #1;
    got.hs = s_hs; got.vs = s_vs; got.da = s_da; got.fs = s_fs;
    got.lq = s_lq; got.ur = s_ur; got.col = s_col; got.row = s_row; got.lr = s_lr;
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got hs/vs/da/fs/lq/ur/col/row/lr=%b expected %b", name, got, want);
    end
  endtask

  task automatic dtick();
    @(posedge clk);
    #1;
  endtask

  task automatic d_reset();
    d_rst = 1'b0; d_ack = 1'b0; d_clr = 1'b0; d_en = 1'b1; d_pix = 1'b1;
    dtick();
    dtick();
    d_rst = 1'b1;
  endtask

  initial begin
    int hk, hh, ln, hs_low0, first_low0, first_low1, da_cnt0, fs_cnt, col_err, row_err, vs_err;
    int run, rise0, rise1, row0, row1, len0, len1, nreq, und_seen;
    logic r, p, e, a, c, prev_lq;
    sobs_t ex;

    s_rst = 1'b0; s_pix = 1'b0; s_en = 1'b0; s_ack = 1'b0; s_clr = 1'b0;
    d_rst = 1'b0; d_pix = 1'b0; d_en = 1'b0; d_ack = 1'b0; d_clr = 1'b0;

    // ---------------- small instance: hand-computed vectors ----------------
    vt[0]  = mkv(0, 1, 1, 0, 0, mko(0, 0, 0, 0, 0, 0, 0, 0, 0));
    vt[1]  = mkv(0, 1, 1, 0, 0, mko(0, 0, 0, 0, 0, 0, 0, 0, 0));
    vt[2]  = mkv(1, 1, 1, 0, 0, mko(0, 0, 1, 1, 0, 0, 0, 0, 0));
    vt[3]  = mkv(1, 1, 1, 0, 0, mko(0, 0, 1, 0, 0, 0, 1, 0, 0));
    vt[4]  = mkv(1, 0, 1, 0, 0, mko(0, 0, 1, 0, 0, 0, 2, 0, 0));
    vt[5]  = mkv(1, 1, 1, 0, 0, mko(0, 0, 1, 0, 0, 0, 2, 0, 0));
    vt[6]  = mkv(1, 1, 1, 0, 0, mko(0, 0, 1, 0, 1, 0, 3, 0, 1));
    vt[7]  = mkv(1, 1, 1, 0, 0, mko(0, 0, 0, 0, 1, 0, 0, 0, 1));
    vt[8]  = mkv(1, 1, 1, 1, 0, mko(1, 0, 0, 0, 0, 0, 0, 0, 1));
    vt[9]  = mkv(1, 1, 1, 0, 0, mko(0, 0, 0, 0, 0, 0, 0, 0, 1));
    vt[10] = mkv(1, 1, 1, 0, 0, mko(0, 0, 1, 0, 0, 0, 0, 1, 1));
    vt[11] = mkv(1, 1, 0, 0, 0, mko(0, 0, 0, 0, 0, 0, 0, 0, 1));
    vt[12] = mkv(1, 0, 1, 0, 0, mko(0, 0, 1, 1, 0, 0, 0, 0, 1));
    vt[13] = mkv(1, 0, 1, 0, 0, mko(0, 0, 1, 0, 0, 0, 0, 0, 1));
    vt[14] = mkv(1, 1, 1, 1, 1, mko(0, 0, 1, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 15; i++)
      s_apply($sformatf("small_vec%0d", i), vt[i].r, vt[i].p, vt[i].e, vt[i].a, vt[i].c, vt[i].exp);

    // ---------------- small instance: model-driven run ----------------
    m_pos = 0; m_lrow = 0; m_org = 1'b1; m_st = 1'b0; m_und = 1'b0;
    for (int i = 0; i < 900; i++) begin
      r = !(i < 2 || i == 400 || i == 401);
      e = !(i >= 250 && i < 254);
      p = (i >= 700 && i < 760) ? 1'b1 : ($urandom % 4 != 0);
      if (i >= 300 && i < 600) a = 1'b0;
      else a = m_st && ($urandom % 3 == 0);
      c = ($urandom % 16 == 0);
      model(r, p, e, a, c, ex);
      s_apply($sformatf("small_run%0d", i), r, p, e, a, c, ex);
    end
    s_rst = 1'b0;

    // ---------------- default instance: reset values ----------------
    d_rst = 1'b0; d_en = 1'b1; d_pix = 1'b1;
    repeat (5) dtick();
    chk("rst_hsync", int'(d_hs), 1);
    chk("rst_vsync", int'(d_vs), 1);
    chk("rst_active", int'(d_da), 0);
    chk("rst_linereq", int'(d_lq), 0);
    chk("rst_underrun", int'(d_ur), 0);
    chk("rst_row", int'(d_row), 0);
    chk("rst_column", int'(d_col), 0);
    chk("rst_framestart", int'(d_fs), 0);

    // ---------------- default: line timing, pixEn every 2nd clk ----------------
    d_rst = 1'b1;
    hs_low0 = 0; first_low0 = -1; first_low1 = -1; da_cnt0 = 0; fs_cnt = 0;
    col_err = 0; row_err = 0; vs_err = 0;
    for (int k = 0; k < 3200; k++) begin
      d_pix = (k % 2 == 0);
      dtick();
      hk = (k + 1) / 2;
      hh = hk % 800;
      ln = hk / 800;
      if (d_hs == 1'b0) begin
        if (k < 1600) begin
          hs_low0++;
          if (first_low0 < 0) first_low0 = k;
        end else if (first_low1 < 0) first_low1 = k;
      end
      if (k < 1600 && d_da) da_cnt0++;
      if (d_fs) fs_cnt++;
      if (int'(d_col) != ((hh < 640) ? hh : 0)) col_err++;
      if (int'(d_row) != ((hh < 640) ? ln : 0)) row_err++;
      if (d_vs !== 1'b1) vs_err++;
    end
    chk("line0_hsync_low_clks", hs_low0, 192);
    chk("line0_hsync_first_low", first_low0, 1311);
    chk("line1_hsync_first_low", first_low1, 2911);
    chk("line0_active_clks", da_cnt0, 1280);
    chk("framestart_count", fs_cnt, 1);
    chk("column_trace_errors", col_err, 0);
    chk("row_trace_errors", row_err, 0);
    chk("vsync_top_lines_errors", vs_err, 0);

    // ---------------- default: ack three clks after request rise ----------------
    d_reset();
    run = 0; rise0 = -1; rise1 = -1; row0 = -1; row1 = -1; len0 = -1; len1 = -1;
    nreq = 0; und_seen = 0; prev_lq = 1'b0;
    for (int k = 0; k < 1700; k++) begin
      dtick();
      if (d_lq && !prev_lq) begin
        if (nreq == 0) begin rise0 = k; row0 = int'(d_lr); end
        if (nreq == 1) begin rise1 = k; row1 = int'(d_lr); end
        nreq++;
      end
      if (d_lq) run++;
      if (!d_lq && prev_lq) begin
        if (nreq == 1) len0 = run;
        if (nreq == 2) len1 = run;
        run = 0;
      end
      if (d_ur) und_seen++;
      prev_lq = d_lq;
      d_ack = d_lq && (run == 4);
    end
    d_ack = 1'b0;
    chk("req0_rise_clk", rise0, 639);
    chk("req0_linerow", row0, 1);
    chk("req0_high_clks", len0, 4);
    chk("req1_rise_clk", rise1, 1439);
    chk("req1_linerow", row1, 2);
    chk("req1_high_clks", len1, 4);
    chk("acked_underrun_clks", und_seen, 0);

    // ---------------- default: never acked, clear, set-beats-clear ----------------
    d_reset();
    for (int k = 0; k < 1603; k++) begin
      d_clr = (k == 851) || (k >= 1597 && k <= 1600);
      dtick();
      if (k == 798) begin
        chk("abandon_pre_underrun", int'(d_ur), 0);
        chk("abandon_pre_linereq", int'(d_lq), 1);
      end
      if (k == 799) begin
        chk("abandon_underrun", int'(d_ur), 1);
        chk("abandon_linereq", int'(d_lq), 0);
      end
      if (k == 850) chk("underrun_sticky", int'(d_ur), 1);
      if (k == 851) chk("underrun_cleared", int'(d_ur), 0);
      if (k == 1598) chk("underrun_before_abandon2", int'(d_ur), 0);
      if (k == 1599) chk("underrun_set_beats_clear", int'(d_ur), 1);
      if (k == 1601) chk("underrun_cleared_after", int'(d_ur), 0);
    end
    d_clr = 1'b0;

    // ---------------- default: ack on the abandon clk ----------------
    d_reset();
    for (int k = 0; k < 900; k++) begin
      d_ack = (k == 799);
      dtick();
      if (k == 798) chk("ack_at_abandon_pre_linereq", int'(d_lq), 1);
      if (k == 799) begin
        chk("ack_at_abandon_linereq", int'(d_lq), 0);
        chk("ack_at_abandon_underrun", int'(d_ur), 0);
      end
      if (k == 899) chk("ack_at_abandon_underrun_late", int'(d_ur), 0);
    end
    d_ack = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
